// File: rtl/fp_mult_arbiter.sv
// Round-robin front end sharing one IEEE-754 single-precision multiplier among N requesters.
// Optional per-requester grant counters are enabled with `define FP_MULT_ARB_STATS_EN.
module fp_mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hold_i,
    input  logic [N-1:0]         req_i,
    input  logic [N*WIDTH-1:0]   a_i,
    input  logic [N*WIDTH-1:0]   b_i,
    output logic [N-1:0]         gnt_o,
    output logic [WIDTH-1:0]     p_o,
    output logic                 p_valid_o,
    output logic [IDW-1:0]       p_id_o,
    output logic                 busy_o
`ifdef FP_MULT_ARB_STATS_EN
    ,
    input  logic                 stat_clr_i,
    output logic [N*16-1:0]      stat_o
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Combinational RNE multiply; subnormals are handled on both inputs and output.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0] ma, mb;
        logic [47:0] m, n, shifted, mask;
        logic        lost, rnd;
        logic [7:0]  expf;
        logic [30:0] mag;
        int          lz, ex, sh;
        logic [31:0] r;

        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_zero = (ea == 8'h00) && (fa == 23'd0);
        b_zero = (eb == 8'h00) && (fb == 23'd0);
        ma      = {ea != 8'h00, fa};
        mb      = {eb != 8'h00, fb};
        m       = {24'd0, ma} * {24'd0, mb};
        n       = '0;
        shifted = '0;
        mask    = '0;
        lost    = 1'b0;
        rnd     = 1'b0;
        expf    = '0;
        mag     = '0;
        lz      = 48;
        sh      = 0;
        r       = '0;

        // Leading-zero count: the highest set bit is written last.
        for (int i = 0; i < 48; i++) begin
            if (m[i]) begin
                lz = 47 - i;
            end
        end
        ex = ((ea == 8'h00) ? 1 : int'(ea)) + ((eb == 8'h00) ? 1 : int'(eb)) - 127 + 1 - lz;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            r = {s, 31'd0};
        end else if (ex >= 255) begin
            r = {s, 8'hFF, 23'd0};
        end else begin
            n = m << lz;
            if (ex <= 0) begin
                sh   = 1 - ex;
                expf = 8'd0;
            end else begin
                sh   = 0;
                expf = ex[7:0];
            end
            if (sh >= 48) begin
                shifted = '0;
                lost    = |n;
            end else begin
                shifted = n >> sh;
                mask    = ~({48{1'b1}} << sh);
                lost    = |(n & mask);
            end
            rnd = shifted[23] & ((|shifted[22:0]) | lost | shifted[24]);
            // A rounding carry ripples into the exponent field, covering subnormal->normal and overflow->inf.
            mag = {expf, shifted[46:24]} + {30'd0, rnd};
            r   = {s, mag};
        end
        return r;
    endfunction

    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    ptr_next;
    logic [N-1:0]     gnt;
    logic [IDW-1:0]   gnt_id;
    logic             accept;
    logic [WIDTH-1:0] a_sel, b_sel, prod;

    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        if (!hold_i && !rst_i) begin
            // Walk offsets downward so the smallest offset from ptr wins.
            for (int i = N - 1; i >= 0; i--) begin
                idx = (int'(ptr_reg) + i) % N;
                if (req_i[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                end
            end
        end
    end

    assign accept   = |gnt;
    assign ptr_next = PW'((int'(gnt_id) + 1) % N);
    assign gnt_o    = gnt;
    assign a_sel    = a_i[gnt_id*WIDTH +: WIDTH];
    assign b_sel    = b_i[gnt_id*WIDTH +: WIDTH];
    assign prod     = WIDTH'(fp_mul(32'(a_sel), 32'(b_sel)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else if (accept) begin
            ptr_reg <= ptr_next;
        end
    end

    logic [LATENCY-1:0] vld_reg;
    logic [WIDTH-1:0]   prod_reg [LATENCY];
    logic [IDW-1:0]     id_reg   [LATENCY];

    // Data moves only with a valid entry so the output holds the last product.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_reg <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                prod_reg[i] <= '0;
                id_reg[i]   <= '0;
            end
        end else if (!hold_i) begin
            vld_reg[0] <= accept;
            if (accept) begin
                prod_reg[0] <= prod;
                id_reg[0]   <= gnt_id;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                if (vld_reg[i-1]) begin
                    prod_reg[i] <= prod_reg[i-1];
                    id_reg[i]   <= id_reg[i-1];
                end
            end
        end
    end

    assign p_o       = prod_reg[LATENCY-1];
    assign p_id_o    = id_reg[LATENCY-1];
    assign p_valid_o = vld_reg[LATENCY-1] & ~hold_i;
    assign busy_o    = |vld_reg;

`ifdef FP_MULT_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg <= '0;
                end else if (stat_clr_i) begin
                    cnt_reg <= '0;
                end else if (gnt[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign stat_o[gi*16 +: 16] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter: FP products, round-robin order, stall, reset and optional stats.
module tb_fp_mult_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] a_bus, b_bus;
    logic [N-1:0]       gnt;
    logic [WIDTH-1:0]   p;
    logic               p_valid;
    logic [IDW-1:0]     p_id;
    logic               busy;
`ifdef FP_MULT_ARB_STATS_EN
    logic               stat_clr;
    logic [N*16-1:0]    stat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mult_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW), .LATENCY(LAT)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .hold_i    (hold),
        .req_i     (req),
        .a_i       (a_bus),
        .b_i       (b_bus),
        .gnt_o     (gnt),
        .p_o       (p),
        .p_valid_o (p_valid),
        .p_id_o    (p_id),
        .busy_o    (busy)
`ifdef FP_MULT_ARB_STATS_EN
        ,
        .stat_clr_i(stat_clr),
        .stat_o    (stat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One isolated request from requester k, checked LAT cycles after acceptance.
    task automatic run_vec(input string tag, input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        req = '0;
        req[k] = 1'b1;
        a_bus[k*WIDTH +: WIDTH] = a;
        b_bus[k*WIDTH +: WIDTH] = b;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
        step();
        req = '0;
        repeat (LAT - 1) step();
        check({tag, "_valid"}, 32'(p_valid), 32'd1);
        check({tag, "_p"}, p, exp);
        check({tag, "_id"}, 32'(p_id), k);
        $display("vec %s: req %0d a=%h b=%h p=%h id=%0d", tag, k, a, b, p, p_id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_rr [4];
        int          q [$];
        int          mptr, acc_cnt, out_cnt;
        logic [N-1:0] exp_gnt;

        rst   = 1'b1;
        hold  = 1'b0;
        req   = '1;
        a_bus = '0;
        b_bus = '0;
`ifdef FP_MULT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(p_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", p, 32'd0);
        check("rst_id", 32'(p_id), 32'd0);
`ifdef FP_MULT_ARB_STATS_EN
        check("rst_stat", stat[31:0], 32'd0);
`endif
        step();
        rst = 1'b0;
        req = '0;

        // Isolated products (one-hot requests are always granted).
        run_vec("mul_2x3",   0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        step();
        check("idle_valid", 32'(p_valid), 32'd0);
        check("idle_hold_p", p, 32'h40C0_0000);
        check("idle_busy", 32'(busy), 32'd0);
        run_vec("mul_sign",  2, 32'h3FC0_0000, 32'hC080_0000, 32'hC0C0_0000);
        run_vec("mul_ovf",   1, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        run_vec("mul_sub",   3, 32'h0080_0000, 32'h3F00_0000, 32'h0040_0000);
        run_vec("mul_nan",   0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        run_vec("mul_rne",   1, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_vec("mul_tie",   2, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
        run_vec("mul_tiny",  3, 32'h0000_0001, 32'h3F00_0000, 32'h0000_0000);

        // Round-robin with all four requesting: products of (k+1)*2.0.
        do_reset();
        a_bus = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        b_bus = {4{32'h4000_0000}};
        exp_rr[0] = 32'h4000_0000;
        exp_rr[1] = 32'h4080_0000;
        exp_rr[2] = 32'h40C0_0000;
        exp_rr[3] = 32'h4100_0000;
        for (int i = 0; i < 11; i++) begin
            req = (i < 8) ? 4'b1111 : 4'b0000;
            #1;
            check($sformatf("rr_gnt%0d", i), 32'(gnt), (i < 8) ? 32'(1 << (i % 4)) : 32'd0);
            check($sformatf("rr_valid%0d", i), 32'(p_valid), (i >= 3) ? 32'd1 : 32'd0);
            if (i >= 3) begin
                check($sformatf("rr_id%0d", i), 32'(p_id), (i - 3) % 4);
                check($sformatf("rr_p%0d", i), p, exp_rr[(i - 3) % 4]);
            end
            $display("rr cycle %0d: gnt=%b valid=%b id=%0d p=%h", i, gnt, p_valid, p_id, p);
            step();
        end
        req = '0;

        // Stall mid-stream with two requesters; scoreboard catches loss or duplication.
        do_reset();
        a_bus = {32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000};
        b_bus = {4{32'h4000_0000}};
        mptr = 0;
        acc_cnt = 0;
        out_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            hold = (i == 4) || (i == 5);
            req  = (i < 8) ? 4'b0011 : 4'b0000;
            #1;
            exp_gnt = (hold || req == 0) ? 4'b0000 : 4'(1 << mptr);
            check($sformatf("st_gnt%0d", i), 32'(gnt), 32'(exp_gnt));
            if (hold) begin
                check($sformatf("st_hvalid%0d", i), 32'(p_valid), 32'd0);
                check($sformatf("st_hbusy%0d", i), 32'(busy), 32'd1);
            end
            if (p_valid) begin
                out_cnt++;
                if (q.size() == 0) begin
                    check($sformatf("st_extra%0d", i), 32'd1, 32'd0);
                end else begin
                    check($sformatf("st_id%0d", i), 32'(p_id), q[0]);
                    check($sformatf("st_p%0d", i), p, (q[0] == 0) ? 32'h4000_0000 : 32'h4080_0000);
                    q.pop_front();
                end
                $display("stall cycle %0d: out id=%0d p=%h", i, p_id, p);
            end
            if (exp_gnt != 0) begin
                q.push_back(mptr);
                acc_cnt++;
                mptr ^= 1;
            end
            step();
        end
        check("st_left", q.size(), 32'd0);
        check("st_count", out_cnt, acc_cnt);
        check("st_accepts", acc_cnt, 32'd6);

        // Reset with two entries in flight.
        do_reset();
        req = 4'b0011;
        #1;
        check("mr_gnt0", 32'(gnt), 32'b0001);
        step();
        check("mr_gnt1", 32'(gnt), 32'b0010);
        step();
        req = '0;
        rst = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(p_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("mr_novalid%0d", i), 32'(p_valid), 32'd0);
        end
        req = 4'b1111;
        #1;
        check("mr_ptr0", 32'(gnt), 32'b0001);
        $display("midreset: post-reset gnt=%b", gnt);
        step();
        req = '0;

`ifdef FP_MULT_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = 4'b0010;
            step();
        end
        req = '0;
        #1;
        check("stat_r1", 32'(stat[31:16]), 32'd5);
        check("stat_r0", 32'(stat[15:0]), 32'd0);
        req = 4'b0010;
        stat_clr = 1'b1;
        step();
        req = '0;
        stat_clr = 1'b0;
        #1;
        check("stat_clr", 32'(stat[31:16]), 32'd0);
        $display("stats: r1=%0d after clear", stat[31:16]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one single-precision floating-point multiplier among N requesters (e.g. the parallel conv-window lanes) with round-robin arbitration.
- Accepts at most one operand pair per cycle. Pushes it through a LATENCY-deep registered multiply pipeline.
- Returns the product tagged with the requester ID.
- Sits between the convolution lane controllers and the shared multiply resource.

Parameters:
- WIDTH, 32, operand/product width (IEEE-754 single).
- N, 4, number of requesters (2..16).
- IDW, 2, requester ID width; must be >= clog2(N).
- LATENCY, 3, registered stages from grant to result (>=1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- hold_i  input  1  pipeline stall; freezes all stages and suppresses grants.
- req_i  input  N  per-requester request, level.
- a_i  input  N*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH].
- b_i  input  N*WIDTH  operand B, same packing.
- gnt_o  output  N  one-hot grant, combinational; the operands are taken when req_i[k] and gnt_o[k] are both high on a clock edge.
- p_o  output  WIDTH  product.
- p_valid_o  output  1  product valid, one-cycle pulse per accepted request.
- p_id_o  output  IDW  requester ID of p_o.
- busy_o  output  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - RR pointer=0.
  - All stage valids=0, so p_valid_o=0 and busy_o=0.
  - p_o=0 and p_id_o=0.
  - gnt_o=0 while reset is asserted.
- Arbitration:
  - gnt_o is the first set req_i bit searching from index ptr upward, wrapping modulo N.
  - If hold_i=1 or req_i=0, then gnt_o=0.
  - At most one bit of gnt_o is set.
- Pointer update: on an accepted grant to k, ptr <= (k+1) mod N. Otherwise ptr is unchanged.
- Stage 1 capture (on acceptance): product = IEEE-754 single multiply of a_k and b_k, round-to-nearest-even. Stage 1 stores the product, the ID k and valid=1.
- Stage advance:
  - Stages 2..LATENCY shift by one each cycle when hold_i=0.
  - With hold_i=1, every stage holds its contents and valid.
  - If nothing is accepted, stage 1 loads valid=0.
- Output:
  - p_o, p_id_o and p_valid_o are driven from stage LATENCY.
  - The result appears exactly LATENCY unstalled cycles after the acceptance edge.
  - p_valid_o is forced 0 while hold_i=1, so a held entry is not reported twice. It is reported on the first cycle after hold_i drops.
  - p_o and p_id_o keep their last value when p_valid_o=0.
- Throughput:
  - One result per cycle when requests are continuous and hold_i=0.
  - With all N requesting constantly, each requester is granted once every N cycles, in order ptr, ptr+1, and so on.
- Boundaries:
  - A requester dropping req_i in the same cycle it would be granted is not granted, and the pointer does not move.
  - A request arriving while hold_i=1 waits; there is no loss.
  - N=1 means gnt_o = req_i & ~hold_i.
  - Reset mid-operation discards all in-flight entries; no p_valid_o is produced for them.
- busy_o is the OR of all stage valids, including stages frozen by hold_i.

Optional Feature:
- Macro FP_MULT_ARB_STATS_EN.
- When defined:
  - Adds an output port stat_o (N*16) with one 16-bit saturating counter per requester, incremented on each accepted grant to that requester.
  - Adds an input port stat_clr_i (1): a synchronous clear that takes priority over an increment in the same cycle.
  - Counters reset to 0 on rst_i and stick at 0xFFFF.
- When not defined: stat_o and stat_clr_i are absent and no counter logic is present.

Test Plan:
- Single request, LATENCY=3: req_i=0001, a0=0x40000000 (2.0), b0=0x40400000 (3.0) for one cycle -> gnt_o=0001 that cycle; 3 cycles later p_valid_o=1, p_o=0x40C00000, p_id_o=0.
- Sign/product check: req_i[2] with a=0x3FC00000 (1.5), b=0xC0800000 (-4.0) -> p_o=0xC0C00000, p_id_o=2.
- Round-robin: req_i=1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; p_id_o follows the same sequence from cycle 3 onward, one pulse per cycle.
- Stall: continuous req_i=0011, then hold_i=1 for 2 cycles mid-stream -> gnt_o=0 and p_valid_o=0 during hold; no product lost or duplicated; the output sequence resumes in order after hold.
- Reset mid-flight: two requests accepted, rst_i asserted 1 cycle later -> p_valid_o stays 0, busy_o=0, ptr=0; the first post-reset request with req_i=1111 is granted to requester 0.
- Stats (FP_MULT_ARB_STATS_EN): 5 grants to requester 1 -> stat_o[31:16]=5; stat_clr_i pulsed on a grant cycle -> counter reads 0 afterwards.
